// File: rtl/mc_table_loader.sv
`default_nettype none
// ============================================================================
//  Module   : mc_table_loader
//  Purpose  : Upstream feeder for one Monte-Carlo core. Accepts a stream of
//             18-bit table words (2^pathWidth sigma words, then T mu words),
//             writes them into the core's idle RAM banks, and when a full set
//             is loaded and the core is idle, flips the bank select and pulses
//             start. The next set is loaded while the core runs the current
//             one, so the two banks are used as a double buffer.
//  Ports    : CLK, RST_N (async active-low)
//             iData/iValid/oReady      - input stream handshake
//             iCoreDone                - core done indication (level)
//             oSigmaWrite*/oSigmaWE    - sigma RAM write port (registered)
//             oMuWrite*/oMuWE          - mu RAM write port (registered)
//             oSwitch, oStart          - bank select / one-cycle start pulse
//             oCoreBusy                - core is running a set
//             oChecksum                - only with MC_LOADER_CHECKSUM_EN
//  Options  : MC_LOADER_CHECKSUM_EN adds a 32-bit running sum of each set,
//             latched into oChecksum when the banks are swapped.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_table_loader #(
   parameter int pathWidth = 10,
   parameter int logT      = 9,
   parameter int T         = 512
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [17:0]          iData,
   input  logic                 iValid,
   output logic                 oReady,
   input  logic                 iCoreDone,
   output logic [pathWidth-1:0] oSigmaWriteAddress,
   output logic [17:0]          oSigmaWriteData,
   output logic                 oSigmaWE,
   output logic [logT-1:0]      oMuWriteAddress,
   output logic [17:0]          oMuWriteData,
   output logic                 oMuWE,
   output logic                 oSwitch,
   output logic                 oStart,
   output logic                 oCoreBusy
`ifdef MC_LOADER_CHECKSUM_EN
   ,
   output logic [31:0]          oChecksum
`endif
);

   // One shared word counter serves both tables, so it is as wide as the
   // larger of the two address spaces.
   localparam int CW = (pathWidth > logT) ? pathWidth : logT;
   localparam logic [CW-1:0] C_SIGMA_LAST = CW'((1 << pathWidth) - 1);
   localparam logic [CW-1:0] C_MU_LAST    = CW'(T - 1);

   typedef enum logic [2:0] {
      S_LOAD_SIGMA = 3'd0,
      S_LOAD_MU    = 3'd1,
      S_WAIT_CORE  = 3'd2,
      S_SWAP       = 3'd3,
      S_START      = 3'd4
   } state_t;

   state_t                 r_state;
   logic [CW-1:0]          r_cnt;
   logic                   r_ready;
   logic                   r_sigma_we;
   logic [pathWidth-1:0]   r_sigma_addr;
   logic [17:0]            r_sigma_data;
   logic                   r_mu_we;
   logic [logT-1:0]        r_mu_addr;
   logic [17:0]            r_mu_data;
   logic                   r_switch;
   logic                   r_start;
   logic                   r_busy;
   logic                   r_done_d;

   logic                   w_xfer;
   logic                   w_done_rise;

   // r_ready is only ever high in the two load states, so a transfer can
   // never happen while waiting for, swapping or starting the core.
   assign w_xfer      = iValid & r_ready;
   assign w_done_rise = iCoreDone & ~r_done_d;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state      <= S_LOAD_SIGMA;
         r_cnt        <= '0;
         r_ready      <= 1'b0;
         r_sigma_we   <= 1'b0;
         r_sigma_addr <= '0;
         r_sigma_data <= '0;
         r_mu_we      <= 1'b0;
         r_mu_addr    <= '0;
         r_mu_data    <= '0;
         r_switch     <= 1'b0;
         r_start      <= 1'b0;
         r_busy       <= 1'b0;
         r_done_d     <= 1'b0;
      end else begin
         r_sigma_we <= 1'b0;
         r_mu_we    <= 1'b0;
         r_start    <= 1'b0;
         r_done_d   <= iCoreDone;

         // Only the rising edge clears busy, so a long done level cannot
         // also cancel the run started after it. The START branch below
         // assigns later and therefore wins over a same-cycle clear.
         if (w_done_rise) begin
            r_busy <= 1'b0;
         end

         case (r_state)
            S_LOAD_SIGMA: begin
               r_ready <= 1'b1;
               if (w_xfer) begin
                  r_sigma_we   <= 1'b1;
                  r_sigma_addr <= r_cnt[pathWidth-1:0];
                  r_sigma_data <= iData;
                  if (r_cnt == C_SIGMA_LAST) begin
                     r_cnt   <= '0;
                     r_state <= S_LOAD_MU;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end

            S_LOAD_MU: begin
               r_ready <= 1'b1;
               if (w_xfer) begin
                  r_mu_we   <= 1'b1;
                  r_mu_addr <= r_cnt[logT-1:0];
                  r_mu_data <= iData;
                  if (r_cnt == C_MU_LAST) begin
                     r_cnt   <= '0;
                     r_ready <= 1'b0;
                     r_state <= S_WAIT_CORE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end

            // The final mu write lands during this state, before the swap.
            S_WAIT_CORE: begin
               r_ready <= 1'b0;
               if (!r_busy) begin
                  r_state <= S_SWAP;
               end
            end

            S_SWAP: begin
               r_ready  <= 1'b0;
               r_switch <= ~r_switch;
               r_start  <= 1'b1;
               r_state  <= S_START;
            end

            S_START: begin
               r_busy  <= 1'b1;
               r_ready <= 1'b1;
               r_state <= S_LOAD_SIGMA;
            end

            default: begin
               r_ready <= 1'b0;
               r_cnt   <= '0;
               r_state <= S_LOAD_SIGMA;
            end
         endcase
      end
   end

   assign oReady             = r_ready;
   assign oSigmaWriteAddress = r_sigma_addr;
   assign oSigmaWriteData    = r_sigma_data;
   assign oSigmaWE           = r_sigma_we;
   assign oMuWriteAddress    = r_mu_addr;
   assign oMuWriteData       = r_mu_data;
   assign oMuWE              = r_mu_we;
   assign oSwitch            = r_switch;
   assign oStart             = r_start;
   assign oCoreBusy          = r_busy;

`ifdef MC_LOADER_CHECKSUM_EN
   logic [31:0] r_sum;
   logic [31:0] r_checksum;

   // The sum is taken at the transfer itself, so the last word of a set is
   // already included by the time SWAP latches it.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sum      <= '0;
         r_checksum <= '0;
      end else begin
         if (r_state == S_START) begin
            r_sum <= '0;
         end else if (w_xfer) begin
            r_sum <= r_sum + {14'd0, iData};
         end
         if (r_state == S_SWAP) begin
            r_checksum <= r_sum;
         end
      end
   end

   assign oChecksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_table_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_table_loader
//  Purpose  : Self-checking bench for mc_table_loader (pathWidth=2, T=4).
//             A reference model tracks each accepted word's position in its
//             set and predicts the RAM write seen one cycle later; scenario
//             code predicts swap/start/busy behaviour from cycle arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mc_table_loader;

   localparam int PW    = 2;
   localparam int LT    = 2;
   localparam int TT    = 4;
   localparam int NSIG  = 1 << PW;
   localparam int NWORD = NSIG + TT;

   logic           CLK = 1'b0;
   logic           RST_N = 1'b0;
   logic [17:0]    iData = '0;
   logic           iValid = 1'b0;
   logic           iCoreDone = 1'b0;
   logic           oReady;
   logic [PW-1:0]  oSigmaWriteAddress;
   logic [17:0]    oSigmaWriteData;
   logic           oSigmaWE;
   logic [LT-1:0]  oMuWriteAddress;
   logic [17:0]    oMuWriteData;
   logic           oMuWE;
   logic           oSwitch;
   logic           oStart;
   logic           oCoreBusy;
`ifdef MC_LOADER_CHECKSUM_EN
   logic [31:0]    oChecksum;
`endif

   mc_table_loader #(.pathWidth(PW), .logT(LT), .T(TT)) u_dut (
      .CLK                (CLK),
      .RST_N              (RST_N),
      .iData              (iData),
      .iValid             (iValid),
      .oReady             (oReady),
      .iCoreDone          (iCoreDone),
      .oSigmaWriteAddress (oSigmaWriteAddress),
      .oSigmaWriteData    (oSigmaWriteData),
      .oSigmaWE           (oSigmaWE),
      .oMuWriteAddress    (oMuWriteAddress),
      .oMuWriteData       (oMuWriteData),
      .oMuWE              (oMuWE),
      .oSwitch            (oSwitch),
      .oStart             (oStart),
      .oCoreBusy          (oCoreBusy)
`ifdef MC_LOADER_CHECKSUM_EN
      ,
      .oChecksum          (oChecksum)
`endif
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_value(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model state ----------------
   logic [17:0] tx_q[$];          // words still to be sent
   int          cyc = 0;          // cycle index, advanced at each posedge
   int          word_idx = 0;     // position of the next accepted word in its set
   bit          p_valid = 1'b0;   // a transfer happened in the previous cycle
   logic [17:0] p_data = '0;
   int          p_idx = 0;
   int          last_xfer_cyc = 0;
   logic [31:0] set_sum = '0;
   bit          chk_en = 1'b0;
   logic [PW-1:0] ls_a = '0;
   logic [17:0]   ls_d = '0;
   logic [LT-1:0] lm_a = '0;
   logic [17:0]   lm_d = '0;
   int          sw_cnt = 0, mw_cnt = 0, start_cnt = 0, start_cyc = 0;

   // Transfer capture: reads the handshake before the DUT updates.
   always @(posedge CLK) begin
      if (!RST_N) begin
         p_valid  = 1'b0;
         word_idx = 0;
      end else begin
         p_valid = iValid && oReady;
         p_data  = iData;
         p_idx   = word_idx;
         if (p_valid) begin
            if (tx_q.size() > 0) void'(tx_q.pop_front());
            set_sum       = set_sum + {14'd0, iData};
            word_idx      = (word_idx + 1) % NWORD;
            last_xfer_cyc = cyc;
         end
      end
      cyc++;
   end

   // Write-port prediction: the word accepted last cycle must appear now,
   // at the table position given by its index in the set.
   always @(negedge CLK) begin
      if (RST_N && chk_en) begin
         bit es, em;
         es = p_valid && (p_idx < NSIG);
         em = p_valid && (p_idx >= NSIG);
         if (es) begin
            ls_a = PW'(p_idx);
            ls_d = p_data;
         end
         if (em) begin
            lm_a = LT'(p_idx - NSIG);
            lm_d = p_data;
         end
         check_value("sigma_we",   32'(oSigmaWE),           32'(es));
         check_value("sigma_addr", 32'(oSigmaWriteAddress), 32'(ls_a));
         check_value("sigma_data", 32'(oSigmaWriteData),    32'(ls_d));
         check_value("mu_we",      32'(oMuWE),              32'(em));
         check_value("mu_addr",    32'(oMuWriteAddress),    32'(lm_a));
         check_value("mu_data",    32'(oMuWriteData),       32'(lm_d));
         if (oSigmaWE) sw_cnt++;
         if (oMuWE)    mw_cnt++;
         if (oStart) begin
            start_cnt++;
            start_cyc = cyc;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge CLK);
         #1;
      end
   endtask

   // mode 0: continuous, 1: iValid every other cycle, 2: random gaps
   task automatic send_set(input int mode);
      int guard;
      guard = 0;
      while (tx_q.size() > 0 && guard < 400) begin
         case (mode)
            0:       iValid = 1'b1;
            1:       iValid = (guard % 2) == 0;
            default: iValid = 1'($urandom_range(0, 1));
         endcase
         iData = tx_q[0];
         step(1);
         guard++;
      end
      iValid = 1'b0;
      check_value("words_accepted", 32'(tx_q.size()), 32'd0);
   endtask

   task automatic wait_start(input int s0, input int bound);
      int k;
      k = 0;
      while (start_cnt == s0 && k < bound) begin
         step(1);
         k++;
      end
      check_value("start_seen", 32'(start_cnt), 32'(s0 + 1));
   endtask

   task automatic new_set_counts();
      sw_cnt    = 0;
      mw_cnt    = 0;
      start_cnt = 0;
      set_sum   = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset state ----
      step(3);
      check_value("rst_outputs",
                  32'({oReady, oSigmaWE, oMuWE, oSwitch, oStart, oCoreBusy}), 32'd0);
      check_value("rst_addr", 32'({oSigmaWriteAddress, oMuWriteAddress}), 32'd0);
      check_value("rst_data", 32'(oSigmaWriteData | oMuWriteData), 32'd0);
      RST_N  = 1'b1;
      chk_en = 1'b1;

      // ---- set 1: data 1..8, continuous, idle core ----
      new_set_counts();
      for (int i = 1; i <= NWORD; i++) tx_q.push_back(18'(i));
      send_set(0);
      wait_start(0, 20);
      check_value("set1_latency", 32'(start_cyc - last_xfer_cyc), 32'd3);
      check_value("set1_switch", 32'(oSwitch), 32'd1);
`ifdef MC_LOADER_CHECKSUM_EN
      check_value("set1_checksum", oChecksum, 32'd36);
`endif
      step(1);
      check_value("set1_start_pulse", 32'(oStart), 32'd0);
      check_value("set1_busy", 32'(oCoreBusy), 32'd1);
      check_value("set1_sigma_we_cnt", 32'(sw_cnt), 32'd4);
      check_value("set1_mu_we_cnt", 32'(mw_cnt), 32'd4);

      // ---- set 2: all 0x3FFFF while core busy, random gaps ----
      new_set_counts();
      for (int i = 0; i < NWORD; i++) tx_q.push_back(18'h3FFFF);
      send_set(2);
      step(5);
      check_value("set2_ready_wait", 32'(oReady), 32'd0);
      check_value("set2_no_start", 32'(start_cnt), 32'd0);
      check_value("set2_switch_hold", 32'(oSwitch), 32'd1);
      check_value("set2_busy_hold", 32'(oCoreBusy), 32'd1);
      iCoreDone = 1'b1;
      step(6);
      iCoreDone = 1'b0;
      wait_start(0, 20);
      check_value("set2_switch", 32'(oSwitch), 32'd0);
`ifdef MC_LOADER_CHECKSUM_EN
      check_value("set2_checksum", oChecksum, 32'h1FFFF8);
`endif
      step(10);
      check_value("set2_one_start", 32'(start_cnt), 32'd1);
      check_value("set2_busy_after_long_done", 32'(oCoreBusy), 32'd1);

      // ---- set 3: iValid every other cycle, random data ----
      new_set_counts();
      for (int i = 0; i < NWORD; i++) tx_q.push_back(18'($urandom));
      send_set(1);
      step(2);
      check_value("set3_sigma_we_cnt", 32'(sw_cnt), 32'd4);
      check_value("set3_mu_we_cnt", 32'(mw_cnt), 32'd4);
      iCoreDone = 1'b1;
      step(1);
      iCoreDone = 1'b0;
      begin
         int k;
         k = 0;
         while (!oStart && k < 20) begin
            step(1);
            k++;
         end
      end
      check_value("set3_start", 32'(oStart), 32'd1);
`ifdef MC_LOADER_CHECKSUM_EN
      check_value("set3_checksum", oChecksum, set_sum);
`endif
      // done rises in the start cycle: belongs to the previous run
      iCoreDone = 1'b1;
      step(1);
      iCoreDone = 1'b0;
      check_value("set3_busy_set_wins", 32'(oCoreBusy), 32'd1);
      step(2);
      check_value("set3_busy_holds", 32'(oCoreBusy), 32'd1);

      // ---- set 4: reset after two mu words ----
      new_set_counts();
      for (int i = 0; i < NSIG + 2; i++) tx_q.push_back(18'($urandom));
      send_set(0);
      check_value("set4_mu_inflight", 32'(oMuWE), 32'd1);
      RST_N = 1'b0;
      #1;
      check_value("midrst_outputs",
                  32'({oReady, oSigmaWE, oMuWE, oSwitch, oStart, oCoreBusy}), 32'd0);
      check_value("midrst_addr", 32'({oSigmaWriteAddress, oMuWriteAddress}), 32'd0);
      ls_a = '0; ls_d = '0; lm_a = '0; lm_d = '0;
      tx_q.delete();
      step(2);
      RST_N = 1'b1;
      step(1);
      // done rising with an idle core is ignored
      iCoreDone = 1'b1;
      step(1);
      iCoreDone = 1'b0;
      step(1);
      check_value("idle_done_ignored", 32'(oCoreBusy), 32'd0);

      // ---- set 5: fresh set after reset, random gaps ----
      new_set_counts();
      for (int i = 0; i < NWORD; i++) tx_q.push_back(18'($urandom));
      send_set(2);
      wait_start(0, 20);
      check_value("set5_latency", 32'(start_cyc - last_xfer_cyc), 32'd3);
      check_value("set5_switch", 32'(oSwitch), 32'd1);
`ifdef MC_LOADER_CHECKSUM_EN
      check_value("set5_checksum", oChecksum, set_sum);
`endif
      check_value("set5_sigma_we_cnt", 32'(sw_cnt), 32'd4);
      check_value("set5_mu_we_cnt", 32'(mw_cnt), 32'd4);
      step(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
